// File: rtl/arcade_input_pkg.sv
// Shared scancodes and joystick-word layout helpers for the arcade input front end.
package arcade_input_pkg;

  localparam logic [7:0] SC_P1_UP     = 8'h75;
  localparam logic [7:0] SC_P1_DOWN   = 8'h72;
  localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
  localparam logic [7:0] SC_P1_BTN0   = 8'h14;
  localparam logic [7:0] SC_P1_BTN0_A = 8'h11;
  localparam logic [7:0] SC_P1_BTN1   = 8'h29;
  localparam logic [7:0] SC_P1_BTN2   = 8'h12;
  localparam logic [7:0] SC_START1    = 8'h05;
  localparam logic [7:0] SC_START2    = 8'h06;
  localparam logic [7:0] SC_COIN1     = 8'h04;
  localparam logic [7:0] SC_PAUSE     = 8'h0C;
  localparam logic [7:0] SC_TEST      = 8'h03;

  localparam logic [7:0] SC_P2_UP     = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P2_BTN0   = 8'h1C;
  localparam logic [7:0] SC_P2_BTN1   = 8'h1B;
  localparam logic [7:0] SC_P2_BTN2   = 8'h15;
  localparam logic [7:0] SC_COIN2     = 8'h0B;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  function automatic int field_width(input int nb);
    return nb + 4;
  endfunction

  function automatic int btn_bit(input int b);
    return 4 + b;
  endfunction

  function automatic int start_bit(input int nb);
    return 4 + nb;
  endfunction

  function automatic int coin_bit(input int nb);
    return 5 + nb;
  endfunction

  function automatic int pause_bit(input int nb);
    return 6 + nb;
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// One-shot coin pulse: a rising edge while idle yields exactly CYCLES low cycles on coin_n.
module arcade_coin_pulse #(
  parameter logic [23:0] CYCLES = 24'd1_200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_raw,
  output logic coin_n
);

  logic [23:0] cnt;
  logic        raw_q;
  logic        fire;

  // Idle only once the counter has expired and the output is back high.
  assign fire = coin_raw & ~raw_q & coin_n & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      raw_q  <= 1'b0;
      coin_n <= 1'b1;
    end else begin
      raw_q  <= coin_raw;
      coin_n <= (cnt == '0);
      if (fire)
        cnt <= CYCLES;
      else if (cnt != '0)
        cnt <= cnt - 24'd1;
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges MiSTer joystick words and PS/2 key events into active-low per-player controls,
// with pause toggle, coin-pulse shaping and per-button autofire.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int          PLAYERS     = 2,
  parameter int          BUTTONS     = 2,
  parameter logic [23:0] COIN_CYCLES = 24'd1_200_000,
  parameter logic [15:0] AF_HALF     = 16'd40_000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [10:0]                               ps2_key,
  input  logic [PLAYERS*16-1:0]                     joy_in,
  input  logic                                      merge,
  input  logic [BUTTONS-1:0]                        af_en,
  input  logic                                      pause_clr,
  output logic [PLAYERS*field_width(BUTTONS)-1:0]   joystick_n,
  output logic [PLAYERS-1:0]                        start_n,
  output logic [PLAYERS-1:0]                        coin_n,
  output logic                                      pause,
  output logic                                      test_n
);

  localparam int FW   = field_width(BUTTONS);
  localparam int BTN0 = btn_bit(0);
  localparam int BTN1 = btn_bit(1);
  localparam int BTN2 = btn_bit(2);
  localparam int SB   = start_bit(BUTTONS);
  localparam int CB   = coin_bit(BUTTONS);
  localparam int PB   = pause_bit(BUTTONS);
  localparam int RW   = CB + 1;

  logic          tog_q;
  logic          ps2_event;
  logic          pressed;
  logic [RW-1:0] key_word [2];
  logic          key_pause;
  logic          key_test;
  logic [RW-1:0] joy_or;
  logic          joy_pause;
  logic          pause_src;
  logic          pause_src_q;
  logic [15:0]   af_cnt;
  logic          af_phase;
  logic          unused_ok;

  assign ps2_event = ps2_key[10] ^ tog_q;
  assign pressed   = ps2_key[9];
  assign unused_ok = ^{ps2_key[8], joy_in};

  // Key state lives in joystick-word layout so it ORs straight into the raw word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q       <= ps2_key[10];
      key_word[0] <= '0;
      key_word[1] <= '0;
      key_pause   <= 1'b0;
      key_test    <= 1'b0;
    end else begin
      tog_q <= ps2_key[10];
      if (ps2_event) begin
        case (ps2_key[7:0])
          SC_P1_UP:                 key_word[0][DIR_UP]    <= pressed;
          SC_P1_DOWN:               key_word[0][DIR_DOWN]  <= pressed;
          SC_P1_LEFT:               key_word[0][DIR_LEFT]  <= pressed;
          SC_P1_RIGHT:              key_word[0][DIR_RIGHT] <= pressed;
          SC_P1_BTN0, SC_P1_BTN0_A: key_word[0][BTN0]      <= pressed;
          SC_P1_BTN1:               if (BUTTONS > 1) key_word[0][BTN1] <= pressed;
          SC_P1_BTN2:               if (BUTTONS > 2) key_word[0][BTN2] <= pressed;
          SC_START1:                key_word[0][SB]        <= pressed;
          SC_COIN1:                 key_word[0][CB]        <= pressed;
          SC_START2:                key_word[1][SB]        <= pressed;
          SC_COIN2:                 key_word[1][CB]        <= pressed;
          SC_P2_UP:                 key_word[1][DIR_UP]    <= pressed;
          SC_P2_DOWN:               key_word[1][DIR_DOWN]  <= pressed;
          SC_P2_LEFT:               key_word[1][DIR_LEFT]  <= pressed;
          SC_P2_RIGHT:              key_word[1][DIR_RIGHT] <= pressed;
          SC_P2_BTN0:               key_word[1][BTN0]      <= pressed;
          SC_P2_BTN1:               if (BUTTONS > 1) key_word[1][BTN1] <= pressed;
          SC_P2_BTN2:               if (BUTTONS > 2) key_word[1][BTN2] <= pressed;
          SC_PAUSE:                 key_pause              <= pressed;
          SC_TEST:                  key_test               <= pressed;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    joy_or    = '0;
    joy_pause = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_or    = joy_or | joy_in[16*p +: RW];
      joy_pause = joy_pause | joy_in[16*p + PB];
    end
  end

  assign pause_src = key_pause | joy_pause;

  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt      <= '0;
      af_phase    <= 1'b0;
      pause       <= 1'b0;
      pause_src_q <= 1'b0;
      test_n      <= 1'b1;
    end else begin
      if (af_cnt == '0) begin
        af_cnt   <= AF_HALF - 16'd1;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt - 16'd1;
      end
      pause_src_q <= pause_src;
      if (pause_clr)
        pause <= 1'b0;
      else if (pause_src & ~pause_src_q)
        pause <= ~pause;
      test_n <= ~key_test;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [RW-1:0]      sel;
    logic [RW-1:0]      key;
    logic [RW-1:0]      raw;
    logic [BUTTONS-1:0] btn;
    logic [FW-1:0]      field_q;
    logic               start_q;

    assign sel = merge ? joy_or : joy_in[16*p +: RW];

    // Players 3 and 4 have no keyboard mapping.
    if (p < 2) begin : g_kbd
      assign key = key_word[p];
    end else begin : g_nokbd
      assign key = '0;
    end

    assign raw = sel | key;
    assign btn = raw[BTN0 +: BUTTONS] & (~af_en | {BUTTONS{af_phase}});

    always_ff @(posedge clk) begin
      if (rst) begin
        field_q <= '1;
        start_q <= 1'b1;
      end else begin
        field_q <= ~{btn, raw[3:0]};
        start_q <= ~raw[SB];
      end
    end

    assign joystick_n[FW*p +: FW] = field_q;
    assign start_n[p]             = start_q;

    arcade_coin_pulse #(.CYCLES(COIN_CYCLES)) u_coin (
      .clk      (clk),
      .rst      (rst),
      .coin_raw (raw[CB]),
      .coin_n   (coin_n[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with a behavioural model compared every cycle.
module tb_arcade_input_ctrl;

  localparam int NP = 3;
  localparam int NB = 2;
  localparam int FW = NB + 4;
  localparam int CC = 8;
  localparam int AFH = 4;

  logic              clk;
  logic              rst;
  logic [10:0]       ps2_key;
  logic [NP*16-1:0]  joy_in;
  logic              merge;
  logic [NB-1:0]     af_en;
  logic              pause_clr;
  logic [NP*FW-1:0]  joystick_n;
  logic [NP-1:0]     start_n;
  logic [NP-1:0]     coin_n;
  logic              pause;
  logic              test_n;

  int n_checks = 0;
  int n_errors = 0;

  arcade_input_ctrl #(
    .PLAYERS(NP), .BUTTONS(NB), .COIN_CYCLES(24'd8), .AF_HALF(16'd4)
  ) dut (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy_in(joy_in), .merge(merge),
    .af_en(af_en), .pause_clr(pause_clr), .joystick_n(joystick_n),
    .start_n(start_n), .coin_n(coin_n), .pause(pause), .test_n(test_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Scancode -> (player, function); functions: 0..3 directions, 4+b button b,
  // 10 start, 11 coin, 12 pause, 13 test.
  function automatic void key_lookup(input logic [7:0] sc, output int pl, output int fn);
    pl = 0;
    fn = -1;
    case (sc)
      8'h74: fn = 0;
      8'h6B: fn = 1;
      8'h72: fn = 2;
      8'h75: fn = 3;
      8'h14, 8'h11: fn = 4;
      8'h29: fn = 5;
      8'h12: fn = 6;
      8'h05: fn = 10;
      8'h04: fn = 11;
      8'h0C: fn = 12;
      8'h03: fn = 13;
      8'h06: begin pl = 1; fn = 10; end
      8'h0B: begin pl = 1; fn = 11; end
      8'h34: begin pl = 1; fn = 0; end
      8'h23: begin pl = 1; fn = 1; end
      8'h2B: begin pl = 1; fn = 2; end
      8'h2D: begin pl = 1; fn = 3; end
      8'h1C: begin pl = 1; fn = 4; end
      8'h1B: begin pl = 1; fn = 5; end
      8'h15: begin pl = 1; fn = 6; end
      default: fn = -1;
    endcase
  endfunction

  bit              kdir [4][4];
  bit              kbtn [4][3];
  bit              kstart [4];
  bit              kcoin [4];
  bit              kpause, ktest, m_tog, m_prevsrc, m_valid;
  bit              m_prevc [NP];
  int              m_pe [NP];
  int              m_k;
  bit [NP*FW-1:0]  m_joy;
  bit [NP-1:0]     m_start, m_coin;
  bit              m_pause, m_test;
  logic [15:0]     w, jor;
  bit              pr, phase, src, rc;
  int              kpl, kfn;

  initial m_valid = 1'b0;

  // Model: outputs after an edge are derived from key state before that edge.
  always @(posedge clk) begin
    if (rst) begin
      foreach (kdir[i, j]) kdir[i][j] = 1'b0;
      foreach (kbtn[i, j]) kbtn[i][j] = 1'b0;
      foreach (kstart[i]) begin kstart[i] = 1'b0; kcoin[i] = 1'b0; end
      kpause = 1'b0; ktest = 1'b0; m_tog = ps2_key[10]; m_prevsrc = 1'b0;
      foreach (m_pe[i]) begin m_pe[i] = -1000; m_prevc[i] = 1'b0; end
      m_k = 0; m_joy = '1; m_start = '1; m_coin = '1; m_pause = 1'b0; m_test = 1'b1;
      m_valid = 1'b1;
    end else begin
      m_k++;
      phase = (m_k >= 2) && ((((m_k - 2) / AFH) % 2) == 0);
      jor = '0;
      src = kpause;
      for (int p = 0; p < NP; p++) begin
        jor = jor | joy_in[16*p +: 16];
        src = src | joy_in[16*p + 6 + NB];
      end
      for (int p = 0; p < NP; p++) begin
        w = merge ? jor : joy_in[16*p +: 16];
        for (int i = 0; i < 4; i++) m_joy[p*FW + i] = !(w[i] | kdir[p][i]);
        for (int b = 0; b < NB; b++) begin
          pr = w[4 + b] | kbtn[p][b];
          if (af_en[b]) pr = pr & phase;
          m_joy[p*FW + 4 + b] = !pr;
        end
        m_start[p] = !(w[4 + NB] | kstart[p]);
        rc = w[5 + NB] | kcoin[p];
        if (rc && !m_prevc[p] && m_k >= m_pe[p] + CC + 2) m_pe[p] = m_k;
        m_prevc[p] = rc;
        m_coin[p] = !(m_k >= m_pe[p] + 1 && m_k <= m_pe[p] + CC);
      end
      if (pause_clr) m_pause = 1'b0;
      else if (src && !m_prevsrc) m_pause = !m_pause;
      m_prevsrc = src;
      m_test = !ktest;
      if (ps2_key[10] != m_tog) begin
        key_lookup(ps2_key[7:0], kpl, kfn);
        pr = ps2_key[9];
        if (kfn >= 0 && kfn <= 3) kdir[kpl][kfn] = pr;
        else if (kfn >= 4 && kfn <= 6) begin
          if (kfn - 4 < NB) kbtn[kpl][kfn - 4] = pr;
        end
        else if (kfn == 10) kstart[kpl] = pr;
        else if (kfn == 11) kcoin[kpl] = pr;
        else if (kfn == 12) kpause = pr;
        else if (kfn == 13) ktest = pr;
      end
      m_tog = ps2_key[10];
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("joystick_n", 32'(joystick_n), 32'(m_joy));
      check("start_n", 32'(start_n), 32'(m_start));
      check("coin_n", 32'(coin_n), 32'(m_coin));
      check("pause", 32'(pause), 32'(m_pause));
      check("test_n", 32'(test_n), 32'(m_test));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ps2(input logic prs, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], prs, 1'b0, sc};
  endtask

  int lows, falls, first, ok_runs, bad_runs, runlen, b5hi;
  logic prevb, firstrun;

  initial begin
    rst = 1'b1; ps2_key = '0; joy_in = '0; merge = 1'b0; af_en = '0; pause_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("rst_joystick_n", 32'(joystick_n), 32'h3FFFF);
    check("rst_start_n", 32'(start_n), 32'h7);
    check("rst_coin_n", 32'(coin_n), 32'h7);
    check("rst_test_n", 32'(test_n), 32'h1);
    check("rst_pause", 32'(pause), 32'h0);

    // Key up press/release: low at N+2, high at N+7.
    ps2(1'b1, 8'h75);
    tick(1); check("up_n1", 32'(joystick_n[3]), 32'h1);
    tick(1); check("up_n2", 32'(joystick_n[3]), 32'h0);
    check("up_p2_field", 32'(joystick_n[11:6]), 32'h3F);
    tick(3); ps2(1'b0, 8'h75);
    tick(1); check("up_n6", 32'(joystick_n[3]), 32'h0);
    tick(1); check("up_n7", 32'(joystick_n[3]), 32'h1);

    // Merge.
    joy_in[31:16] = 16'h0010; merge = 1'b1;
    tick(1); check("merge_on", 32'({joystick_n[16], joystick_n[10], joystick_n[4]}), 32'h0);
    merge = 1'b0;
    tick(1); check("merge_off", 32'({joystick_n[16], joystick_n[10], joystick_n[4]}), 32'h5);
    joy_in = '0; tick(2);

    // btn2 key has no effect with two buttons; shared btn0 keys, last event wins.
    ps2(1'b1, 8'h12); tick(3);
    check("btn2_ignored", 32'(joystick_n[5:0]), 32'h3F);
    ps2(1'b0, 8'h12); tick(1);
    ps2(1'b1, 8'h14); tick(1);
    ps2(1'b0, 8'h11); tick(1);
    check("btn0_shared_press", 32'(joystick_n[4]), 32'h0);
    tick(1); check("btn0_shared_release", 32'(joystick_n[4]), 32'h1);

    // P2 directions from two back-to-back events.
    ps2(1'b1, 8'h2D); tick(1);
    ps2(1'b1, 8'h34); tick(2);
    check("p2_up_right", 32'(joystick_n[11:6]), 32'h36);
    check("p2_p1_clean", 32'(joystick_n[5:0]), 32'h3F);
    ps2(1'b0, 8'h2D); tick(1); ps2(1'b0, 8'h34); tick(3);

    // Coin held 100 cycles gives one 8-cycle pulse starting at N+2.
    joy_in[15:0] = 16'h0080;
    lows = 0; falls = 0; first = -1; prevb = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (!coin_n[0]) begin lows++; if (first < 0) first = i; end
      if (prevb && !coin_n[0]) falls++;
      prevb = coin_n[0];
    end
    check("coin_first", 32'(first), 32'd2);
    check("coin_lows", 32'(lows), 32'd8);
    check("coin_pulses", 32'(falls), 32'd1);
    joy_in = '0; tick(3);
    joy_in[15:0] = 16'h0080;
    lows = 0;
    for (int i = 1; i <= 30; i++) begin tick(1); if (!coin_n[0]) lows++; end
    check("coin_repress_lows", 32'(lows), 32'd8);
    joy_in = '0; tick(2);

    // Key coin2.
    ps2(1'b1, 8'h0B);
    lows = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (!coin_n[1]) begin lows++; if (first < 0) first = i; end
    end
    check("coin2_first", 32'(first), 32'd3);
    check("coin2_lows", 32'(lows), 32'd8);
    ps2(1'b0, 8'h0B); tick(2);

    // Reset aborts an active pulse on player 3.
    joy_in[47:32] = 16'h0080;
    tick(4); check("coin3_active", 32'(coin_n[2]), 32'h0);
    rst = 1'b1;
    tick(1); check("coin_rst_abort", 32'(coin_n), 32'h7);
    rst = 1'b0; joy_in = '0; tick(2);

    // Autofire on btn0 only.
    af_en = 2'b01; joy_in[15:0] = 16'h0030;
    tick(1);
    ok_runs = 0; bad_runs = 0; b5hi = 0; runlen = 1; firstrun = 1'b1;
    prevb = joystick_n[4];
    for (int i = 1; i < 40; i++) begin
      tick(1);
      if (joystick_n[5]) b5hi++;
      if (joystick_n[4] == prevb) runlen++;
      else begin
        if (!firstrun) begin
          if (runlen == AFH) ok_runs++; else bad_runs++;
        end
        firstrun = 1'b0; runlen = 1; prevb = joystick_n[4];
      end
    end
    check("af_bad_runs", 32'(bad_runs), 32'd0);
    check("af_runs_seen", 32'(ok_runs >= 5), 32'd1);
    check("af_btn1_steady", 32'(b5hi), 32'd0);
    af_en = '0; joy_in = '0; tick(2);

    // Pause toggles, clear priority.
    ps2(1'b1, 8'h0C); tick(1); ps2(1'b0, 8'h0C); tick(3);
    check("pause_on", 32'(pause), 32'h1);
    ps2(1'b1, 8'h0C); tick(1); ps2(1'b0, 8'h0C); tick(3);
    check("pause_off", 32'(pause), 32'h0);
    joy_in[15:0] = 16'h0100; pause_clr = 1'b1;
    tick(1); pause_clr = 1'b0;
    tick(3); check("pause_clr_priority", 32'(pause), 32'h0);
    joy_in = '0; tick(2);
    joy_in[47:32] = 16'h0100;
    tick(2); check("pause_p3_joy", 32'(pause), 32'h1);
    joy_in = '0; pause_clr = 1'b1;
    tick(1); check("pause_clr", 32'(pause), 32'h0);
    pause_clr = 1'b0; tick(1);

    // Start and test keys.
    ps2(1'b1, 8'h05); tick(1);
    ps2(1'b1, 8'h06); tick(1);
    ps2(1'b1, 8'h03); tick(2);
    check("start_keys", 32'(start_n), 32'h4);
    check("test_key", 32'(test_n), 32'h0);
    ps2(1'b0, 8'h05); tick(1);
    ps2(1'b0, 8'h06); tick(1);
    ps2(1'b0, 8'h03); tick(3);
    check("keys_released", 32'({test_n, start_n}), 32'hF);

    tick(5);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
